uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Byte queue and launch controller sitting directly upstream of the `Uart8` transmitter. It accepts bytes from a producer at up to one per clock and buffers them in a circular FIFO. It then feeds them one at a time into the Uart8 tx interface (`txStart`/`txIn`/`txBusy`/`txDone`). This lets firmware-side logic post bursts without watching the serial line.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `START_TIMEOUT`, 4095: clocks to wait in START for `txBusy` before abandoning the byte; ≥1.
- `clk` in 1: system clock, rising edge.
- `rstN` in 1: reset, asynchronous, active-low; one clock, no other clock domains.
- `en` in 1: launch enable; low holds queued bytes. Does not block pushes.
- `wrEn` in 1: push `wrData` this cycle.
- `wrData` in 8: byte to queue.
- `clrOverflow` in 1: clears `overflow`.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out clog2(DEPTH)+1: bytes stored, excluding the byte in flight.
- `overflow` out 1: sticky; set when a push is dropped.
- `startErr` out 1: one-cycle pulse on START timeout.
- `busy` out 1: state != IDLE.
- `txStart` out 1: to Uart8 `txStart`.
- `txIn` out 8: to Uart8 `txIn`.
- `txBusy` in 1: from Uart8.
- `txDone` in 1: from Uart8.

## Operation
- Storage: DEPTH×8 array; `wrPtr`/`rdPtr` are clog2(DEPTH) bits and wrap modulo DEPTH; `count` is held separately. `full` and `empty` derive combinationally from the registered `count`.
- Push: `wrEn && (!full || pop)` writes `wrData` at `wrPtr`, then `wrPtr++`.
  - `wrEn && full && !pop` drops the byte and sets `overflow`.
- Overflow clear: `clrOverflow` clears `overflow`. If a drop happens in the same cycle, set wins.
- Pop: occurs only on the IDLE→START transition. It latches mem[`rdPtr`] into the `txIn` register, then `rdPtr++`.
- Count: `count` += push − pop. Simultaneous push and pop at full leaves `count` = DEPTH; simultaneous push and pop at empty is impossible, since a pop needs !empty.
- FSM states: IDLE, START, DRAIN.
  - IDLE: if `en && !empty && !txBusy` → pop, go to START.
  - START: `txStart`=1, `txIn` stable.
    - On `txBusy`=1 → DRAIN.
    - Otherwise the timeout counter increments. When it reaches START_TIMEOUT → IDLE, pulse `startErr`; the byte is discarded, not requeued.
  - DRAIN: `txStart`=0. On `txDone`=1 or `txBusy`=0 → IDLE.
- `txIn` holds its last value outside START; it changes only on a pop.
- `en` falling mid-frame: the current frame completes normally (START/DRAIN ignore `en`). No further pops occur.
- Reset, including mid-frame: all state is cleared immediately. The FIFO contents are logically discarded (pointers zeroed; the array need not be cleared). `txStart` drops asynchronously; the Uart8 frame in progress is not this block's concern.

## Timing
- All outputs are registered, except `full`/`empty`/`busy`, which decode from registers.
- Reset values: `txStart`=0, `txIn`=8'h00, `count`=0, `empty`=1, `full`=0, `overflow`=0, `startErr`=0, `busy`=0, state=IDLE, pointers=0, timeout counter=0.
- Push at edge N: `count`/`empty` update after edge N. The earliest pop is at edge N+1. `txStart`=1 after edge N+1; the first launch latency is 2 clocks from `wrEn`.
- `txStart` and `txIn` change on the same edge, so `txIn` is valid whenever `txStart`=1.
- `txStart` stays high through the edge where `txBusy`=1 is sampled, and is low the following cycle.
- DRAIN→IDLE costs 1 clock. The next pop happens no earlier than the cycle after returning to IDLE, giving a minimum 2-clock gap with `txStart` low between frames.
- Timeout counter: cleared on entering START. `startErr` is high for exactly the cycle after expiry, coincident with state=IDLE.

## Test plan
- Single byte: push 8'h8A with `en`=1; Uart8 model raises `txBusy` 3 clocks later → `txStart` high 2 clocks after push, `txIn`=8'h8A. `txStart` drops the cycle after `txBusy`, `empty`=1 throughout. `busy` falls 1 clock after `txDone`.
- Burst: push 8'h00..8'h0F back-to-back with `en`=0 → `full`=1, `count`=16. Raise `en` → bytes leave in order 8'h00..8'h0F with a ≥2-clock `txStart`-low gap between frames. End state `empty`=1.
- Overflow: fill 16 with `en`=0, push 8'hFF → `count` stays 16, `overflow`=1, 8'hFF never transmitted. Pulse `clrOverflow` → `overflow`=0.
- Push/pop at full: full FIFO, `en`=1, push 8'h55 on the pop cycle → `count` stays 16, `overflow`=0, 8'h55 transmitted last.
- Timeout: START_TIMEOUT=8, `txBusy` tied 0, push 8'h11 → `txStart` high 8 clocks, then `startErr` pulses 1 cycle. State is IDLE and the byte is gone.
- Reset mid-DRAIN: 3 bytes queued, assert `rstN`=0 while in DRAIN → all outputs at reset values asynchronously. After release with `en`=1, no `txStart`.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO and launch controller feeding a Uart8 transmitter.
// Bytes are pushed at up to one per clock. Each byte is popped into txIn and
// offered with txStart, which stays high until the transmitter reports txBusy.
// Ports:
//   clk, rstN           - clock and async active-low reset
//   en                  - launch enable (pushes are never blocked by it)
//   wrEn, wrData        - push strobe and byte
//   clrOverflow         - clears the sticky overflow flag
//   full, empty, count  - FIFO occupancy (count excludes the byte in flight)
//   overflow            - sticky flag, set when a push is dropped
//   startErr            - one-cycle pulse when txBusy never arrived
//   busy                - controller is not idle
//   txStart, txIn       - launch request and byte to Uart8
//   txBusy, txDone      - status from Uart8
module uart_tx_queue #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned START_TIMEOUT = 4095
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     en,
  input  logic                     wrEn,
  input  logic [7:0]               wrData,
  input  logic                     clrOverflow,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     startErr,
  output logic                     busy,
  output logic                     txStart,
  output logic [7:0]               txIn,
  input  logic                     txBusy,
  input  logic                     txDone
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [TW-1:0]   tmo_q;
  logic            ovf_q;
  logic            ovf_d;
  logic            err_q;
  logic            tx_start_q;
  logic [7:0]      tx_in_q;
  logic [7:0]      mem [DEPTH];

  logic            pop_c;
  logic            push_c;
  logic            drop_c;

  // Occupancy decodes straight from the registered count.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign startErr = err_q;
  assign txStart  = tx_start_q;
  assign txIn     = tx_in_q;

  // A pop frees a slot in the same cycle, so a push at full is accepted then.
  always_comb begin
    pop_c   = 1'b0;
    push_c  = 1'b0;
    drop_c  = 1'b0;
    count_d = count_q;
    ovf_d   = ovf_q;
    pop_c   = (state_q == S_IDLE) && en && !empty && !txBusy;
    push_c  = wrEn && (!full || pop_c);
    drop_c  = wrEn && full && !pop_c;
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (clrOverflow) begin
      ovf_d = 1'b0;
    end
  end

  // Storage array; no reset, pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= wrData;
    end
  end

  // Pointers, flags and the launch FSM.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_in_q    <= 8'h00;
    end else begin
      err_q   <= 1'b0;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        tx_in_q  <= mem[rd_ptr_q];
      end
      case (state_q)
        S_IDLE: begin
          if (pop_c) begin
            state_q    <= S_START;
            tx_start_q <= 1'b1;
            tmo_q      <= '0;
          end
        end
        S_START: begin
          if (txBusy) begin
            state_q    <= S_DRAIN;
            tx_start_q <= 1'b0;
          end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
            // Transmitter never answered: abandon the byte.
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            err_q      <= 1'b1;
            tmo_q      <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_DRAIN: begin
          if (txDone || !txBusy) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_start_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic       clk, rstN, en, wrEn, clrOverflow, txBusy, txDone;
  logic [7:0] wrData;
  logic       full, empty, overflow, startErr, busy, txStart;
  logic [4:0] count;
  logic [7:0] txIn;

  uart_tx_queue #(.DEPTH(DEPTH), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rstN(rstN), .en(en), .wrEn(wrEn), .wrData(wrData),
    .clrOverflow(clrOverflow), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .startErr(startErr), .busy(busy), .txStart(txStart),
    .txIn(txIn), .txBusy(txBusy), .txDone(txDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue plus the phase of the byte in flight.
  byte unsigned mq[$];
  int           m_ph;    // 0 none, 1 offered, 2 being sent
  int           m_wait;
  bit           m_ov, m_err;
  logic [7:0]   m_txin;

  // Uart8 stand-in.
  bit           u_on, u_never, u_rand;
  int           u_lat, u_len, u_ph, u_cnt;
  byte unsigned ulog[$];

  // Frame gap tracking.
  bit ts_prev;
  int low_run, min_gap, frames;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       en;
    logic       clr;
    logic       bsy;
    logic       dn;
    logic [4:0] cnt;
    logic       emp;
    logic       ts;
    logic [7:0] ti;
    logic       bz;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ph = 0; m_wait = 0; m_ov = 0; m_err = 0; m_txin = 8'h00;
  endtask

  task automatic model_step();
    bit pop, drop;
    int n;
    n    = mq.size();
    pop  = (m_ph == 0) && en && (n > 0) && !txBusy;
    drop = wrEn && (n == DEPTH) && !pop;
    m_err = 0;
    if (m_ph == 1) begin
      if (txBusy) m_ph = 2;
      else begin
        m_wait++;
        if (m_wait == TO) begin m_ph = 0; m_err = 1; end
      end
    end else if (m_ph == 2) begin
      if (txDone || !txBusy) m_ph = 0;
    end
    if (pop) begin
      m_txin = mq.pop_front();
      m_ph = 1;
      m_wait = 0;
    end
    if (wrEn && !drop) mq.push_back(wrData);
    if (drop) m_ov = 1;
    else if (clrOverflow) m_ov = 0;
  endtask

  task automatic check_model();
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_empty", 32'(empty), 32'(mq.size() == 0));
    chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("m_overflow", 32'(overflow), 32'(m_ov));
    chk("m_txStart", 32'(txStart), 32'(m_ph == 1));
    chk("m_txIn", 32'(txIn), 32'(m_txin));
    chk("m_busy", 32'(busy), 32'(m_ph != 0));
    chk("m_startErr", 32'(startErr), 32'(m_err));
  endtask

  task automatic uart_step();
    txDone = 1'b0;
    if (u_ph == 0) begin
      if (txStart) begin
        if (u_cnt == 0 && u_rand) begin
          u_never = ($urandom_range(0, 9) == 0);
          u_lat   = $urandom_range(1, 4);
          u_len   = $urandom_range(1, 5);
        end
        u_cnt++;
        if (!u_never && u_cnt >= u_lat) begin
          txBusy = 1'b1;
          ulog.push_back(txIn);
          u_ph = 1;
          u_cnt = 0;
        end
      end else begin
        u_cnt = 0;
      end
    end else begin
      u_cnt++;
      if (u_cnt >= u_len) begin
        txBusy = 1'b0;
        txDone = 1'b1;
        u_ph = 0;
        u_cnt = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    if (u_on) uart_step();
    if (txStart && !ts_prev) begin
      if (frames > 0 && low_run < min_gap) min_gap = low_run;
      frames++;
    end
    if (!txStart) low_run++;
    else low_run = 0;
    ts_prev = txStart;
  endtask

  initial begin
    int hi, errs, k;

    tbl[0] = '{1'b1, 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'h8A, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'h8A, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'h8A, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h8A, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h8A, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h8A, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h8A, 1'b0};

    rstN = 1'b0; en = 1'b0; wrEn = 1'b0; wrData = 8'h00; clrOverflow = 1'b0;
    txBusy = 1'b0; txDone = 1'b0;
    u_on = 0; u_never = 0; u_rand = 0; u_lat = 1; u_len = 1; u_ph = 0; u_cnt = 0;
    ts_prev = 0; low_run = 0; min_gap = 1000; frames = 0;
    model_reset();

    // Reset values.
    #1;
    chk("rst_txStart", 32'(txStart), 0);
    chk("rst_txIn", 32'(txIn), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_startErr", 32'(startErr), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Single byte, cycle by cycle.
    for (int i = 0; i < 8; i++) begin
      wrEn = tbl[i].wr; wrData = tbl[i].d; en = tbl[i].en; clrOverflow = tbl[i].clr;
      txBusy = tbl[i].bsy; txDone = tbl[i].dn;
      cycle();
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d_txStart", i), 32'(txStart), 32'(tbl[i].ts));
      chk($sformatf("tbl%0d_txIn", i), 32'(txIn), 32'(tbl[i].ti));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
    end
    wrEn = 1'b0; txBusy = 1'b0; txDone = 1'b0;

    // Burst fill with launch held off.
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wrEn = 1'b1; wrData = 8'(i);
      cycle();
    end
    chk("burst_full", 32'(full), 1);
    chk("burst_count", 32'(count), 16);

    // Overflow drop and clear.
    wrData = 8'hFF;
    cycle();
    wrEn = 1'b0;
    chk("ovf_count", 32'(count), 16);
    chk("ovf_set", 32'(overflow), 1);
    clrOverflow = 1'b1;
    cycle();
    clrOverflow = 1'b0;
    chk("ovf_clear", 32'(overflow), 0);

    // Push on the pop cycle at full, then drain in order.
    u_on = 1; u_never = 0; u_rand = 0; u_lat = 2; u_len = 3;
    ulog.delete(); frames = 0; min_gap = 1000;
    en = 1'b1; wrEn = 1'b1; wrData = 8'h55;
    cycle();
    wrEn = 1'b0;
    chk("pp_count", 32'(count), 16);
    chk("pp_overflow", 32'(overflow), 0);
    chk("pp_first_txIn", 32'(txIn), 32'h00);
    k = 0;
    while (k < 400 && !(empty && !busy && u_ph == 0)) begin
      cycle();
      k++;
    end
    chk("burst_drained", 32'(empty && !busy), 1);
    chk("burst_nbytes", 32'(ulog.size()), 17);
    for (int i = 0; i < 17; i++) begin
      logic [7:0] want;
      want = (i < 16) ? 8'(i) : 8'h55;
      chk($sformatf("burst_byte%0d", i), (i < ulog.size()) ? 32'(ulog[i]) : 32'hDEAD, 32'(want));
    end
    chk("burst_gap_ge2", 32'(min_gap >= 2), 1);

    // START timeout with the transmitter never answering.
    u_never = 1;
    wrEn = 1'b1; wrData = 8'h11;
    cycle();
    wrEn = 1'b0;
    hi = 0; errs = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (txStart) hi++;
      if (startErr) begin
        errs++;
        chk("to_idle_at_err", 32'(busy), 0);
      end
    end
    chk("to_txStart_cycles", 32'(hi), 8);
    chk("to_err_pulses", 32'(errs), 1);
    chk("to_byte_gone", 32'(count), 0);

    // Asynchronous reset while draining a frame.
    u_never = 0; u_lat = 1; u_len = 6;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wrEn = 1'b1; wrData = 8'(8'hA1 + i);
      cycle();
    end
    wrEn = 1'b0; en = 1'b1;
    k = 0;
    while (k < 20 && m_ph != 2) begin
      cycle();
      k++;
    end
    chk("rd_in_drain", 32'(busy && !txStart), 1);
    rstN = 1'b0;
    #2;
    chk("rd_txStart", 32'(txStart), 0);
    chk("rd_count", 32'(count), 0);
    chk("rd_empty", 32'(empty), 1);
    chk("rd_busy", 32'(busy), 0);
    chk("rd_txIn", 32'(txIn), 0);
    chk("rd_overflow", 32'(overflow), 0);
    model_reset();
    txBusy = 1'b0; txDone = 1'b0; u_ph = 0; u_cnt = 0;
    @(negedge clk);
    rstN = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (txStart) hi++;
    end
    chk("rd_no_launch", 32'(hi), 0);

    // Randomized traffic against the model.
    u_rand = 1;
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      wrEn = ($urandom_range(0, 99) < 55);
      wrData = 8'($urandom);
      clrOverflow = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 19) == 0) en = ~en;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
